// File: rtl/ccd_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ccd_cfg_pkg
// Shared definitions for the CCD sensor register update scheduler:
//   - register index encoding (EXP=0, R=1, B=2, G1=3, G2=4)
//   - sensor register addresses
//   - scheduler FSM state encoding
//   - helpers: fixed-priority pick over the pending vector, index->address
// No ports (package).
// ---------------------------------------------------------------------------
package ccd_cfg_pkg;

   localparam int NUM_REGS = 5;

   // Index encoding doubles as the bit position in the pending vector
   // {G2,G1,B,R,EXP}; a lower index means a higher issue priority.
   localparam logic [2:0] IDX_EXP = 3'd0;
   localparam logic [2:0] IDX_R   = 3'd1;
   localparam logic [2:0] IDX_B   = 3'd2;
   localparam logic [2:0] IDX_G1  = 3'd3;
   localparam logic [2:0] IDX_G2  = 3'd4;

   localparam logic [7:0] ADDR_EXP = 8'h09;
   localparam logic [7:0] ADDR_G1  = 8'h2B;
   localparam logic [7:0] ADDR_B   = 8'h2C;
   localparam logic [7:0] ADDR_R   = 8'h2D;
   localparam logic [7:0] ADDR_G2  = 8'h2E;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_RETRY     = 3'd3,
      ST_DROP      = 3'd4
   } state_t;

   // Fixed priority EXP > R > B > G1 > G2, i.e. lowest set bit wins.
   function automatic logic [2:0] pick_idx(input logic [4:0] p);
      logic [2:0] idx;
      idx = IDX_EXP;
      if (p[0])      idx = IDX_EXP;
      else if (p[1]) idx = IDX_R;
      else if (p[2]) idx = IDX_B;
      else if (p[3]) idx = IDX_G1;
      else if (p[4]) idx = IDX_G2;
      return idx;
   endfunction

   function automatic logic [7:0] idx_addr(input logic [2:0] idx);
      logic [7:0] a;
      case (idx)
         IDX_EXP: a = ADDR_EXP;
         IDX_R:   a = ADDR_R;
         IDX_B:   a = ADDR_B;
         IDX_G1:  a = ADDR_G1;
         IDX_G2:  a = ADDR_G2;
         default: a = ADDR_EXP;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ccd_sync2.sv
// ---------------------------------------------------------------------------
// ccd_sync2
// Two-flop synchroniser bringing an asynchronous level into the CLK domain.
// Ports:
//   CLK    in  1  destination clock
//   RESET  in  1  synchronous active-high reset (both flops clear to 0)
//   d      in  1  asynchronous level
//   q      out 1  synchronised level, two CLK cycles of latency
// ---------------------------------------------------------------------------
module ccd_sync2 (
   input  logic CLK,
   input  logic RESET,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ccd_reg_update_scheduler.sv
// ---------------------------------------------------------------------------
// ccd_reg_update_scheduler
// Watches the exposure / gain values coming from the SoC PIO, detects
// changes against a per-register shadow of what the sensor holds, and
// sequences the resulting register writes onto the single I2C write engine.
// Writes are only started during vertical blank (synchronised FVAL low), at
// most MAX_PER_VBL per blank interval, with NACK/timeout retries.
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   iFVAL                   frame valid (asynchronous, synchronised here)
//   iExposure .. iGreen2G   requested register values (16 bit each)
//   oI2C_REQ/ADDR/DATA      write request towards the I2C engine
//   iI2C_ACK                engine accepted the request (1-cycle pulse)
//   iI2C_DONE/iI2C_NACK     transfer finished / sensor NACK flag
//   oPENDING                pending bits {G2,G1,B,R,EXP}
//   oBUSY                   FSM is not IDLE
//   oERR                    sticky: a write was dropped after retries
//   oWR_COUNT               successful write counter (wraps)
//   oSTATE                  current FSM state (debug visibility)
//
// Engine handshake: oI2C_REQ rises with ADDR/DATA already valid and both
// stay stable until the engine pulses iI2C_ACK; REQ drops the cycle after
// ACK. Exactly one iI2C_DONE pulse then follows (possibly in the ACK cycle
// itself), with iI2C_NACK qualifying it. A missing DONE is treated as NACK
// once TIMEOUT_CYC cycles have passed since ACK.
// ---------------------------------------------------------------------------
module ccd_reg_update_scheduler
   import ccd_cfg_pkg::*;
#(
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 65535,
   parameter int MAX_PER_VBL = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        iFVAL,
   input  logic [15:0] iExposure,
   input  logic [15:0] iRedG,
   input  logic [15:0] iBlueG,
   input  logic [15:0] iGreen1G,
   input  logic [15:0] iGreen2G,
   output logic        oI2C_REQ,
   output logic [7:0]  oI2C_ADDR,
   output logic [15:0] oI2C_DATA,
   input  logic        iI2C_ACK,
   input  logic        iI2C_DONE,
   input  logic        iI2C_NACK,
   output logic [4:0]  oPENDING,
   output logic        oBUSY,
   output logic        oERR,
   output logic [15:0] oWR_COUNT,
   output logic [2:0]  oSTATE
);

   // ------------------------------------------------------------------
   // Frame-valid synchronisation and blank detection
   // ------------------------------------------------------------------
   logic fval_s;
   logic fval_q;
   logic vbl;
   logic fval_fall;

   ccd_sync2 u_fval_sync (
      .CLK   (CLK),
      .RESET (RESET),
      .d     (iFVAL),
      .q     (fval_s)
   );

   always_ff @(posedge CLK) begin
      if (RESET) fval_q <= 1'b0;
      else       fval_q <= fval_s;
   end

   assign vbl       = ~fval_s;
   assign fval_fall = fval_q & ~fval_s;

   // ------------------------------------------------------------------
   // Requested values, shadows and pending detection
   // ------------------------------------------------------------------
   logic [15:0] in_val     [NUM_REGS];
   logic [15:0] shadow     [NUM_REGS];
   logic [15:0] shadow_nxt [NUM_REGS];
   logic [4:0]  force_q;
   logic [4:0]  force_nxt;
   logic [4:0]  pending_q;

   assign in_val[IDX_EXP] = iExposure;
   assign in_val[IDX_R]   = iRedG;
   assign in_val[IDX_B]   = iBlueG;
   assign in_val[IDX_G1]  = iGreen1G;
   assign in_val[IDX_G2]  = iGreen2G;

   state_t      state;
   logic [2:0]  hold_idx;
   logic [3:0]  retry;
   logic [15:0] timer;
   logic [2:0]  vbl_cnt;

   // Outcome of the current transfer, seen either in ISSUE (ACK and DONE
   // in the same cycle) or in WAIT_DONE.
   logic in_xfer;
   logic wr_ok;
   logic xfer_fail;
   logic shadow_we;
   logic retry_ok;
   logic can_start;
   logic [2:0] sel_idx;

   assign in_xfer   = ((state == ST_ISSUE) && iI2C_ACK) || (state == ST_WAIT_DONE);
   assign wr_ok     = in_xfer && iI2C_DONE && !iI2C_NACK;
   assign xfer_fail = (in_xfer && iI2C_DONE && iI2C_NACK) ||
                      ((state == ST_WAIT_DONE) && !iI2C_DONE && (timer == 16'(TIMEOUT_CYC)));
   assign shadow_we = wr_ok || (state == ST_DROP);
   assign retry_ok  = retry < 4'(MAX_RETRY);
   assign can_start = (|pending_q) && vbl && (vbl_cnt < 3'(MAX_PER_VBL));
   assign sel_idx   = pick_idx(pending_q);

   // The shadow is loaded with the data that actually went out (held in
   // oI2C_DATA), not the live input, so a mid-transfer change re-raises
   // pending and is sent afterwards.
   always_comb begin
      force_nxt = force_q;
      for (int i = 0; i < NUM_REGS; i++) shadow_nxt[i] = shadow[i];
      if (shadow_we) begin
         shadow_nxt[hold_idx] = oI2C_DATA;
         force_nxt[hold_idx]  = 1'b0;
      end
   end

   // Pending is computed from the next shadow so the register written this
   // cycle cannot look pending for one stale cycle after returning to IDLE.
   // force_q keeps every register pending after reset until it is written.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 16'h0000;
         force_q   <= 5'b11111;
         pending_q <= 5'b11111;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i]    <= shadow_nxt[i];
            pending_q[i] <= force_nxt[i] | (in_val[i] != shadow_nxt[i]);
         end
         force_q <= force_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Writes started in the current blank interval
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET)
         vbl_cnt <= 3'd0;
      else if (fval_fall)
         vbl_cnt <= 3'd0;
      else if ((state == ST_ISSUE) && iI2C_ACK && (vbl_cnt != 3'd7))
         vbl_cnt <= vbl_cnt + 3'd1;
   end

   // ------------------------------------------------------------------
   // Scheduler FSM
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         oI2C_REQ  <= 1'b0;
         oI2C_ADDR <= 8'h00;
         oI2C_DATA <= 16'h0000;
         hold_idx  <= IDX_EXP;
         retry     <= 4'd0;
         timer     <= 16'h0000;
         oERR      <= 1'b0;
         oWR_COUNT <= 16'h0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (can_start) begin
                  hold_idx  <= sel_idx;
                  oI2C_ADDR <= idx_addr(sel_idx);
                  oI2C_DATA <= in_val[sel_idx];
                  retry     <= 4'd0;
                  oI2C_REQ  <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (iI2C_ACK) begin
                  oI2C_REQ <= 1'b0;
                  timer    <= 16'h0000;
                  if (wr_ok) begin
                     oWR_COUNT <= oWR_COUNT + 16'd1;
                     state     <= ST_IDLE;
                  end else if (xfer_fail) begin
                     if (retry_ok) begin
                        retry <= retry + 4'd1;
                        state <= ST_RETRY;
                     end else begin
                        state <= ST_DROP;
                     end
                  end else begin
                     state <= ST_WAIT_DONE;
                  end
               end
            end

            ST_WAIT_DONE: begin
               timer <= timer + 16'd1;
               if (wr_ok) begin
                  oWR_COUNT <= oWR_COUNT + 16'd1;
                  state     <= ST_IDLE;
               end else if (xfer_fail) begin
                  if (retry_ok) begin
                     retry <= retry + 4'd1;
                     state <= ST_RETRY;
                  end else begin
                     state <= ST_DROP;
                  end
               end
            end

            // Re-issue with the same hold registers, but only in blank.
            ST_RETRY: begin
               if (vbl) begin
                  oI2C_REQ <= 1'b1;
                  state    <= ST_ISSUE;
               end
            end

            // Shadow takes the held data (see shadow_we) so the dropped
            // value is not retried forever.
            ST_DROP: begin
               oERR  <= 1'b1;
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign oPENDING = pending_q;
   assign oBUSY    = (state != ST_IDLE);
   assign oSTATE   = state;

endmodule

// File: tb/tb_ccd_reg_update_scheduler.sv
module tb_ccd_reg_update_scheduler;

   localparam int T_OUT = 40;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        iFVAL;
   logic [15:0] iExposure, iRedG, iBlueG, iGreen1G, iGreen2G;
   logic        oI2C_REQ;
   logic [7:0]  oI2C_ADDR;
   logic [15:0] oI2C_DATA;
   logic        iI2C_ACK, iI2C_DONE, iI2C_NACK;
   logic [4:0]  oPENDING;
   logic        oBUSY, oERR;
   logic [15:0] oWR_COUNT;
   logic [2:0]  oSTATE;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_wr = 0;

   // engine log and expected write sequence {addr,data}
   logic [7:0]  log_addr[$];
   logic [15:0] log_data[$];
   int          log_cyc[$];
   logic [23:0] exp_q[$];

   // engine behaviour knobs
   logic [7:0] nack_addr = 8'hFF;
   logic [7:0] hang_addr = 8'hFF;
   int         done_dly  = 0;
   logic [7:0] eng_a;
   logic       eng_nack;

   ccd_reg_update_scheduler #(
      .MAX_RETRY   (3),
      .TIMEOUT_CYC (T_OUT),
      .MAX_PER_VBL (5)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .iFVAL     (iFVAL),
      .iExposure (iExposure),
      .iRedG     (iRedG),
      .iBlueG    (iBlueG),
      .iGreen1G  (iGreen1G),
      .iGreen2G  (iGreen2G),
      .oI2C_REQ  (oI2C_REQ),
      .oI2C_ADDR (oI2C_ADDR),
      .oI2C_DATA (oI2C_DATA),
      .iI2C_ACK  (iI2C_ACK),
      .iI2C_DONE (iI2C_DONE),
      .iI2C_NACK (iI2C_NACK),
      .oPENDING  (oPENDING),
      .oBUSY     (oBUSY),
      .oERR      (oERR),
      .oWR_COUNT (oWR_COUNT),
      .oSTATE    (oSTATE)
   );

   // ---------------- clock / cycle counter ----------------
   always #10 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   // ---------------- I2C engine model ----------------
   initial begin
      iI2C_ACK = 1'b0; iI2C_DONE = 1'b0; iI2C_NACK = 1'b0;
      forever begin
         @(negedge CLK);
         iI2C_ACK = 1'b0; iI2C_DONE = 1'b0; iI2C_NACK = 1'b0;
         if (RESET === 1'b0 && oI2C_REQ === 1'b1) begin
            eng_a    = oI2C_ADDR;
            eng_nack = (eng_a == nack_addr);
            log_addr.push_back(oI2C_ADDR);
            log_data.push_back(oI2C_DATA);
            log_cyc.push_back(cyc);
            iI2C_ACK = 1'b1;
            if (eng_a != hang_addr && done_dly == 0) begin
               iI2C_DONE = 1'b1; iI2C_NACK = eng_nack;
            end
            @(negedge CLK);
            iI2C_ACK = 1'b0; iI2C_DONE = 1'b0; iI2C_NACK = 1'b0;
            if (eng_a != hang_addr && done_dly > 0) begin
               for (int k = 1; k < done_dly && RESET === 1'b0; k++) @(negedge CLK);
               if (RESET === 1'b0) begin
                  iI2C_DONE = 1'b1; iI2C_NACK = eng_nack;
                  @(negedge CLK);
                  iI2C_DONE = 1'b0; iI2C_NACK = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_log();
      log_addr.delete(); log_data.delete(); log_cyc.delete(); exp_q.delete();
   endtask

   task automatic fval_pulse(input int len);
      iFVAL = 1'b1;
      repeat (len) @(negedge CLK);
      iFVAL = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < budget) begin
         @(negedge CLK);
         n++;
         if (oBUSY === 1'b0 && oPENDING === 5'd0) quiet++;
         else quiet = 0;
      end
      total++;
      if (quiet < 4) begin
         $display("FAIL %s_idle_timeout busy=%b pending=%b want idle within %0d cycles", name, oBUSY, oPENDING, budget);
         bad++;
      end
   endtask

   task automatic wait_log(input string name, input int n, input int budget);
      int k = 0;
      while (log_addr.size() < n && k < budget) begin
         @(negedge CLK);
         k++;
      end
      total++;
      if (log_addr.size() < n) begin
         $display("FAIL %s_req_timeout got=%0d requests want=%0d", name, log_addr.size(), n);
         bad++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET = 1'b1; iFVAL = 1'b0;
      iExposure = 16'h0; iRedG = 16'h0; iBlueG = 16'h0; iGreen1G = 16'h0; iGreen2G = 16'h0;
      repeat (3) @(negedge CLK);
      total++; if (oI2C_REQ !== 1'b0)      begin $display("FAIL rst_req got=%b want=0", oI2C_REQ); bad++; end
      total++; if (oI2C_ADDR !== 8'h00)    begin $display("FAIL rst_addr got=%h want=00", oI2C_ADDR); bad++; end
      total++; if (oI2C_DATA !== 16'h0000) begin $display("FAIL rst_data got=%h want=0000", oI2C_DATA); bad++; end
      total++; if (oERR !== 1'b0)          begin $display("FAIL rst_err got=%b want=0", oERR); bad++; end
      total++; if (oWR_COUNT !== 16'h0000) begin $display("FAIL rst_wrcnt got=%h want=0000", oWR_COUNT); bad++; end
      total++; if (oBUSY !== 1'b0)         begin $display("FAIL rst_busy got=%b want=0", oBUSY); bad++; end
      total++; if (oPENDING !== 5'b11111)  begin $display("FAIL rst_pending got=%b want=11111", oPENDING); bad++; end
      total++; if (oSTATE !== S_IDLE)      begin $display("FAIL rst_state got=%0d want=0", oSTATE); bad++; end
      clear_log();
      RESET = 1'b0;
   endtask

   task automatic test_full_config();
      done_dly = 0;
      exp_q = '{24'h09_0000, 24'h2D_0000, 24'h2C_0000, 24'h2B_0000, 24'h2E_0000};
      wait_idle("cfg", 200);
      exp_wr = 5;
      total++; if (log_addr.size() != exp_q.size()) begin $display("FAIL cfg_count got=%0d want=%0d", log_addr.size(), exp_q.size()); bad++; end
      for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
         total++;
         if ({log_addr[i], log_data[i]} !== exp_q[i]) begin $display("FAIL cfg_write[%0d] got=%h want=%h", i, {log_addr[i], log_data[i]}, exp_q[i]); bad++; end
      end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL cfg_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
      total++; if (oPENDING !== 5'd0) begin $display("FAIL cfg_pending got=%b want=00000", oPENDING); bad++; end
      total++; if (oERR !== 1'b0) begin $display("FAIL cfg_err got=%b want=0", oERR); bad++; end
   endtask

   task automatic test_fval_block();
      int req_seen = 0;
      fval_pulse(10);
      clear_log();
      iFVAL = 1'b1;
      repeat (5) @(negedge CLK);
      iRedG = 16'h0020;
      for (int i = 0; i < 1000; i++) begin
         @(negedge CLK);
         if (oI2C_REQ !== 1'b0) req_seen++;
      end
      total++; if (req_seen != 0) begin $display("FAIL fval_req_in_frame got=%0d cycles want=0", req_seen); bad++; end
      total++; if (oPENDING !== 5'b00010) begin $display("FAIL fval_pending got=%b want=00010", oPENDING); bad++; end
      iFVAL = 1'b0;
      wait_idle("fval", 100);
      exp_wr += 1;
      exp_q = '{24'h2D_0020};
      total++; if (log_addr.size() != 1) begin $display("FAIL fval_count got=%0d want=1", log_addr.size()); bad++; end
      if (log_addr.size() > 0) begin
         total++;
         if ({log_addr[0], log_data[0]} !== exp_q[0]) begin $display("FAIL fval_write got=%h want=%h", {log_addr[0], log_data[0]}, exp_q[0]); bad++; end
      end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL fval_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_latency();
      clear_log();
      iGreen1G = 16'h0005;
      @(negedge CLK);
      total++; if (oPENDING !== 5'b01000) begin $display("FAIL lat_pending got=%b want=01000", oPENDING); bad++; end
      total++; if (oI2C_REQ !== 1'b0) begin $display("FAIL lat_req_early got=%b want=0", oI2C_REQ); bad++; end
      @(negedge CLK);
      total++; if (oI2C_REQ !== 1'b1 || oI2C_ADDR !== 8'h2B || oI2C_DATA !== 16'h0005) begin
         $display("FAIL lat_req got=%b/%h/%h want=1/2b/0005", oI2C_REQ, oI2C_ADDR, oI2C_DATA); bad++;
      end
      wait_idle("lat", 100);
      exp_wr += 1;
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL lat_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_priority();
      fval_pulse(10);
      clear_log();
      iExposure = 16'h0400; iBlueG = 16'h0010;
      wait_idle("prio_a", 100);
      iRedG = 16'h0030; iGreen1G = 16'h0006; iGreen2G = 16'h0007;
      wait_idle("prio_b", 100);
      // five writes done this blank: the next change must wait for a new blank
      iExposure = 16'h0401;
      repeat (50) @(negedge CLK);
      total++; if (log_addr.size() != 5) begin $display("FAIL prio_limit_count got=%0d want=5", log_addr.size()); bad++; end
      total++; if (oPENDING !== 5'b00001) begin $display("FAIL prio_limit_pending got=%b want=00001", oPENDING); bad++; end
      fval_pulse(10);
      wait_idle("prio_c", 100);
      exp_wr += 6;
      exp_q = '{24'h09_0400, 24'h2C_0010, 24'h2D_0030, 24'h2B_0006, 24'h2E_0007, 24'h09_0401};
      total++; if (log_addr.size() != exp_q.size()) begin $display("FAIL prio_count got=%0d want=%0d", log_addr.size(), exp_q.size()); bad++; end
      for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
         total++;
         if ({log_addr[i], log_data[i]} !== exp_q[i]) begin $display("FAIL prio_write[%0d] got=%h want=%h", i, {log_addr[i], log_data[i]}, exp_q[i]); bad++; end
      end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL prio_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_revert();
      clear_log();
      iFVAL = 1'b1;
      repeat (5) @(negedge CLK);
      iRedG = 16'h0099;
      repeat (3) @(negedge CLK);
      total++; if (oPENDING !== 5'b00010) begin $display("FAIL rev_pending_set got=%b want=00010", oPENDING); bad++; end
      iRedG = 16'h0030;
      repeat (3) @(negedge CLK);
      total++; if (oPENDING !== 5'b00000) begin $display("FAIL rev_pending_clr got=%b want=00000", oPENDING); bad++; end
      iFVAL = 1'b0;
      repeat (30) @(negedge CLK);
      total++; if (log_addr.size() != 0) begin $display("FAIL rev_count got=%0d want=0", log_addr.size()); bad++; end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL rev_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_nack();
      fval_pulse(10);
      clear_log();
      nack_addr = 8'h2B;
      iGreen1G = 16'h0077;
      wait_idle("nack", 200);
      nack_addr = 8'hFF;
      total++; if (log_addr.size() != 4) begin $display("FAIL nack_count got=%0d want=4", log_addr.size()); bad++; end
      for (int i = 0; i < log_addr.size(); i++) begin
         total++;
         if ({log_addr[i], log_data[i]} !== 24'h2B_0077) begin $display("FAIL nack_write[%0d] got=%h want=2b0077", i, {log_addr[i], log_data[i]}); bad++; end
      end
      total++; if (oERR !== 1'b1) begin $display("FAIL nack_err got=%b want=1", oERR); bad++; end
      total++; if (oPENDING !== 5'd0) begin $display("FAIL nack_pending got=%b want=00000", oPENDING); bad++; end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL nack_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_timeout();
      int gap;
      fval_pulse(10);
      clear_log();
      hang_addr = 8'h2C;
      iBlueG = 16'h0055;
      wait_idle("tmo", 1000);
      hang_addr = 8'hFF;
      total++; if (log_addr.size() != 4) begin $display("FAIL tmo_count got=%0d want=4", log_addr.size()); bad++; end
      if (log_cyc.size() >= 2) begin
         gap = log_cyc[1] - log_cyc[0];
         total++;
         if (gap < T_OUT || gap > T_OUT + 4) begin $display("FAIL tmo_gap got=%0d want=%0d..%0d", gap, T_OUT, T_OUT + 4); bad++; end
      end
      total++; if (oPENDING !== 5'd0) begin $display("FAIL tmo_pending got=%b want=00000", oPENDING); bad++; end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL tmo_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_change_mid();
      fval_pulse(10);
      clear_log();
      done_dly = 20;
      iGreen2G = 16'h0011;
      wait_log("mid", 1, 20);
      repeat (2) @(negedge CLK);
      total++; if (oSTATE !== S_WAIT) begin $display("FAIL mid_state got=%0d want=%0d", oSTATE, S_WAIT); bad++; end
      iGreen2G = 16'h0022;
      wait_idle("mid", 200);
      done_dly = 0;
      exp_wr += 2;
      exp_q = '{24'h2E_0011, 24'h2E_0022};
      total++; if (log_addr.size() != exp_q.size()) begin $display("FAIL mid_count got=%0d want=%0d", log_addr.size(), exp_q.size()); bad++; end
      for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
         total++;
         if ({log_addr[i], log_data[i]} !== exp_q[i]) begin $display("FAIL mid_write[%0d] got=%h want=%h", i, {log_addr[i], log_data[i]}, exp_q[i]); bad++; end
      end
      total++; if (oWR_COUNT !== 16'(exp_wr)) begin $display("FAIL mid_wrcnt got=%0d want=%0d", oWR_COUNT, exp_wr); bad++; end
   endtask

   task automatic test_reset_mid();
      fval_pulse(10);
      clear_log();
      done_dly = 50;
      iExposure = 16'h0123;
      wait_log("rmid", 1, 20);
      repeat (3) @(negedge CLK);
      total++; if (oSTATE !== S_WAIT) begin $display("FAIL rmid_state_pre got=%0d want=%0d", oSTATE, S_WAIT); bad++; end
      RESET = 1'b1;
      @(negedge CLK);
      total++; if (oI2C_REQ !== 1'b0)      begin $display("FAIL rmid_req got=%b want=0", oI2C_REQ); bad++; end
      total++; if (oBUSY !== 1'b0)         begin $display("FAIL rmid_busy got=%b want=0", oBUSY); bad++; end
      total++; if (oERR !== 1'b0)          begin $display("FAIL rmid_err got=%b want=0", oERR); bad++; end
      total++; if (oWR_COUNT !== 16'h0000) begin $display("FAIL rmid_wrcnt got=%0d want=0", oWR_COUNT); bad++; end
      total++; if (oPENDING !== 5'b11111)  begin $display("FAIL rmid_pending got=%b want=11111", oPENDING); bad++; end
      total++; if (oSTATE !== S_IDLE)      begin $display("FAIL rmid_state got=%0d want=0", oSTATE); bad++; end
      done_dly = 0;
      repeat (2) @(negedge CLK);
      clear_log();
      RESET = 1'b0;
      wait_idle("rmid", 200);
      exp_q = '{24'h09_0123, 24'h2D_0030, 24'h2C_0055, 24'h2B_0077, 24'h2E_0022};
      total++; if (log_addr.size() != exp_q.size()) begin $display("FAIL rmid_count got=%0d want=%0d", log_addr.size(), exp_q.size()); bad++; end
      for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
         total++;
         if ({log_addr[i], log_data[i]} !== exp_q[i]) begin $display("FAIL rmid_write[%0d] got=%h want=%h", i, {log_addr[i], log_data[i]}, exp_q[i]); bad++; end
      end
      total++; if (oWR_COUNT !== 16'd5) begin $display("FAIL rmid_wrcnt_after got=%0d want=5", oWR_COUNT); bad++; end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_full_config();
      test_fval_block();
      test_latency();
      test_priority();
      test_revert();
      test_nack();
      test_timeout();
      test_change_mid();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
